// File: rtl/rcas_serial_seq_if.sv
// Handshake/bus bundle for rcas_serial_seq: request side (in_*, a, b, sel)
// and result side (out_*, result, status flags).
interface rcas_serial_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, a, b, sel, out_ready,
    input  in_ready, out_valid, result, c_out, ovf, zero, neg
  );

  modport slave (
    input  in_valid, a, b, sel, out_ready,
    output in_ready, out_valid, result, c_out, ovf, zero, neg
  );
endinterface

// File: rtl/rcas_serial_seq.sv
// Digit-serial add/subtract sequencer around one 4-bit ripple-carry slice.
// Optional macro RCAS_SEQ_FLAGS_EN: when defined, ovf/zero/neg are computed
// and registered with the result; otherwise they are tied to 0.

// 4-bit ripple-carry adder/subtractor slice; sub inverts b, c_in supplies +1.
module rcas_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sub,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);
  logic [3:0] bx;
  logic [4:0] c;

  // Ripple the carry through four full adders.
  always_comb begin
    bx   = b ^ {4{sub}};
    c    = '0;
    sum  = '0;
    c[0] = c_in;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ bx[i] ^ c[i];
      c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
    c_out = c[4];
  end
endmodule

// state | meaning
// IDLE  | ready for a new operation (in_ready high)
// RUN   | one nibble per cycle through the slice, LSB nibble first
// DONE  | result registers valid, waiting for out_ready
module rcas_serial_seq #(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  rcas_serial_seq_if.slave  bus
);
  localparam int N  = WIDTH / 4;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             sel_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [3:0]       dig;
  logic             dig_c;
  logic [WIDTH-1:0] r_next;

`ifdef RCAS_SEQ_FLAGS_EN
  logic             a_msb;
  logic             b_msb;
`endif

  rcas_4bit u_slice (
    .a     (a_sh[3:0]),
    .b     (b_sh[3:0]),
    .sub   (sel_q),
    .c_in  (carry),
    .sum   (dig),
    .c_out (dig_c)
  );

  // The final nibble is still in flight on the DONE-entry edge, so the
  // output registers load from the post-shift value rather than r_sh.
  assign r_next = {dig, r_sh[WIDTH-1:4]};

  // Ready comes from registered state only; reset masks it.
  assign bus.in_ready = (state == IDLE) && !rst;

`ifndef RCAS_SEQ_FLAGS_EN
  assign bus.ovf  = 1'b0;
  assign bus.zero = 1'b0;
  assign bus.neg  = 1'b0;
`endif

  // Sequencer FSM with datapath shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      a_sh          <= '0;
      b_sh          <= '0;
      r_sh          <= '0;
      sel_q         <= 1'b0;
      carry         <= 1'b0;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.c_out     <= 1'b0;
`ifdef RCAS_SEQ_FLAGS_EN
      a_msb         <= 1'b0;
      b_msb         <= 1'b0;
      bus.ovf       <= 1'b0;
      bus.zero      <= 1'b0;
      bus.neg       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            sel_q <= bus.sel;
            carry <= bus.sel;
            cnt   <= '0;
            state <= RUN;
`ifdef RCAS_SEQ_FLAGS_EN
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          a_sh  <= {4'b0000, a_sh[WIDTH-1:4]};
          b_sh  <= {4'b0000, b_sh[WIDTH-1:4]};
          r_sh  <= r_next;
          carry <= dig_c;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.result    <= r_next;
            bus.c_out     <= dig_c;
`ifdef RCAS_SEQ_FLAGS_EN
            bus.ovf  <= (a_msb == (b_msb ^ sel_q)) && (r_next[WIDTH-1] != a_msb);
            bus.zero <= (r_next == '0);
            bus.neg  <= r_next[WIDTH-1];
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rcas_serial_seq.sv
// Self-checking bench for rcas_serial_seq (WIDTH=32): directed literal cases
// plus randomized back-to-back traffic against an arithmetic reference model.
module tb_rcas_serial_seq;
  localparam int W = 32;
  localparam int N = W / 4;
`ifdef RCAS_SEQ_FLAGS_EN
  localparam bit FLG = 1'b1;
`else
  localparam bit FLG = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         ovf;
    logic         zero;
    logic         neg;
  } res_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  longint cyc    = 0;

  rcas_serial_seq_if #(.WIDTH(W)) bus ();

  rcas_serial_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: plain wide/signed arithmetic.
  function automatic res_t calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    res_t         x;
    longint       sa;
    longint       sb;
    longint       sr;
    logic [W:0]   w;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!s) begin
      w   = {1'b0, a} + {1'b0, b};
      x.r = w[W-1:0];
      x.c = w[W];
      sr  = sa + sb;
    end else begin
      x.r = a - b;
      x.c = (a >= b);
      sr  = sa - sb;
    end
    x.ovf  = FLG && ((sr > 64'sd2147483647) || (sr < -64'sd2147483648));
    x.zero = FLG && (x.r == '0);
    x.neg  = FLG && x.r[W-1];
    return x;
  endfunction

  // Transaction-level model: accept -> result visible N cycles later -> consumed.
  int   m_phase = 0;   // 0 waiting for request, 1 computing, 2 holding result
  int   m_cnt   = 0;
  res_t m_pend  = '0;
  res_t m_out   = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_phase <= 0;
      m_cnt   <= 0;
      m_out   <= '0;
    end else begin
      case (m_phase)
        0: if (bus.in_valid) begin
             m_pend  <= calc(bus.a, bus.b, bus.sel);
             m_cnt   <= 1;
             m_phase <= 1;
           end
        1: if (m_cnt == N) begin
             m_phase <= 2;
             m_out   <= m_pend;
           end else begin
             m_cnt <= m_cnt + 1;
           end
        default: if (bus.out_ready) m_phase <= 0;
      endcase
    end
  end

  // Compare every output on every cycle against the model.
  always @(negedge clk) begin
    chk("in_ready",  {63'd0, bus.in_ready},  {63'd0, (m_phase == 0) && !rst});
    chk("out_valid", {63'd0, bus.out_valid}, {63'd0, (m_phase == 2)});
    chk("result",    {32'd0, bus.result},    {32'd0, m_out.r});
    chk("c_out",     {63'd0, bus.c_out},     {63'd0, m_out.c});
    chk("ovf",       {63'd0, bus.ovf},       {63'd0, m_out.ovf});
    chk("zero",      {63'd0, bus.zero},      {63'd0, m_out.zero});
    chk("neg",       {63'd0, bus.neg},       {63'd0, m_out.neg});
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] er, input logic ec,
                        input logic eo, input logic ez, input logic en, input bit rel);
    int lat;
    chk({name, " ready"}, {63'd0, bus.in_ready}, 64'd1);
    bus.a = a; bus.b = b; bus.sel = s; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({name, " latency"}, 64'(lat), 64'(N));
    chk({name, " result"}, {32'd0, bus.result}, {32'd0, er});
    chk({name, " c_out"},  {63'd0, bus.c_out},  {63'd0, ec});
    chk({name, " ovf"},    {63'd0, bus.ovf},    {63'd0, FLG & eo});
    chk({name, " zero"},   {63'd0, bus.zero},   {63'd0, FLG & ez});
    chk({name, " neg"},    {63'd0, bus.neg},    {63'd0, FLG & en});
    if (rel) begin
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      chk({name, " back to idle"}, {62'd0, bus.in_ready, bus.out_valid}, 64'd2);
    end
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'hFFFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'h0000_0000;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int     seen;
    int     t;
    longint last_acc;
    longint acc;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sel = 1'b0; bus.out_ready = 1'b0;
    repeat (3) step();
    chk("in_ready during reset", {63'd0, bus.in_ready}, 64'd0);
    rst = 1'b0;
    #1;
    chk("in_ready after reset", {63'd0, bus.in_ready}, 64'd1);
    chk("reset result", {32'd0, bus.result}, 64'd0);
    chk("reset flags", {59'd0, bus.out_valid, bus.c_out, bus.ovf, bus.zero, bus.neg}, 64'd0);
    step();

    run_op("add wrap", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    run_op("sub 5-7",  32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_op("add ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    run_op("sub ovf",  32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

    // Stall in DONE while new requests are offered.
    run_op("stall op", 32'h0000_00FF, 32'h0000_0F00, 1'b0, 32'h0000_0FFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.a = W'($urandom); bus.b = W'($urandom); bus.sel = 1'($urandom);
      step();
      chk("stall in_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("stall result", {31'd0, bus.out_valid, bus.result}, {31'd1, 32'h0000_0FFF});
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("stall release", {62'd0, bus.in_ready, bus.out_valid}, 64'd2);

    // Reset in the middle of RUN discards the operation.
    bus.a = 32'hDEAD_BEEF; bus.b = 32'h0123_4567; bus.sel = 1'b0; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    #1;
    chk("mid-run rst in_ready", {63'd0, bus.in_ready}, 64'd0);
    step();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.out_valid) seen = 1;
      step();
    end
    chk("aborted op out_valid", 64'(seen), 64'd0);
    chk("aborted op outputs", {27'd0, bus.result, bus.c_out, bus.ovf, bus.zero, bus.neg}, 64'd0);
    run_op("after rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back random traffic.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    last_acc = 0;
    for (int i = 0; i < 1000; i++) begin
      bus.a = rnd_opnd(); bus.b = rnd_opnd(); bus.sel = 1'($urandom);
      t = 0;
      while (!bus.in_ready && t < 30) begin
        step();
        t++;
      end
      if (!bus.in_ready) begin
        chk("b2b accept timeout", 64'(t), 64'd0);
        break;
      end
      acc = cyc + 1;
      if (i > 0) chk("b2b spacing", 64'(acc - last_acc), 64'(N + 2));
      last_acc = acc;
      step();
    end
    bus.in_valid = 1'b0;
    repeat (N + 4) step();
    bus.out_ready = 1'b0;
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rcas_serial_seq.md
# rcas_serial_seq

Digit-serial add/subtract sequencer that sits directly upstream of the 4-bit ripple-carry adder/subtractor slice `rcas_4bit` and instantiates it. It accepts one WIDTH-bit operation through a valid/ready handshake and feeds the slice one nibble per cycle, LSB nibble first, registering the inter-nibble carry. It assembles the full result and returns it through a second valid/ready handshake. The block gives a 32-bit add/sub for the area of one 4-bit slice plus registers.

## Interface
- `WIDTH`, default 32: operand width; must be a multiple of 4 and ≥ 8. N = WIDTH/4 digit cycles.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `a`  in  WIDTH  operand A; sampled on acceptance.
- `b`  in  WIDTH  operand B; sampled on acceptance.
- `sel`  in  1  0 = A+B, 1 = A−B; sampled on acceptance.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  WIDTH  sum/difference, modulo 2^WIDTH.
- `c_out`  out  1  carry out of MSB. For subtract, 1 means no borrow (A ≥ B unsigned).
- `ovf`  out  1  signed overflow.
- `zero`  out  1  result == 0.
- `neg`  out  1  result[WIDTH-1].

One clock; reset is synchronous and active-high.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid`&&`in_ready`: latch `a`, `b`, `sel` into shift registers A_sh and B_sh.
  - Set the carry register to `sel` (two's-complement +1).
  - Clear the digit counter. Go to RUN.
- RUN, one nibble per cycle:
  - Slice inputs: A_sh[3:0], B_sh[3:0], `sel`, and the carry register.
  - A_sh and B_sh shift right by 4.
  - The slice result nibble shifts into R_sh from the top.
  - The carry register takes the slice `c_out`.
  - The counter increments. After the N-th digit, go to DONE.
- On entry to DONE, output registers load:
  - `result` = R_sh.
  - `c_out` = final carry.
  - Flags per Configuration.
- Output registers hold their values until the next DONE entry. They are stable for the whole time `out_valid` = 1.
- DONE:
  - `out_valid` = 1.
  - On `out_ready`, go to IDLE on that edge.
  - While `out_ready` = 0, hold; `in_valid` is ignored (`in_ready` = 0).
- Signed overflow = (A[MSB] == (B[MSB]^sel)) && (result[MSB] != A[MSB]).
- Counter width is $clog2(N)+1. There is no wrap: the count is exactly N.

## Timing
- Acceptance on edge E0. RUN occupies edges E1..EN. `out_valid` rises after edge EN, i.e. N cycles after acceptance (8 for WIDTH=32).
- Minimum issue interval is N+2 cycles (DONE→IDLE takes one edge; IDLE accepts on the next).
- `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from `in_valid` or `out_ready` to either.
- Reset values:
  - state IDLE, so `in_ready` = 1 once `rst` is low.
  - `out_valid` = 0.
  - `result` = 0, `c_out` = 0, `ovf` = 0, `zero` = 0, `neg` = 0.
  - Internal shift registers, carry register and counter = 0.
- While `rst` = 1, `in_ready` = 0.
- Reset mid-RUN or in DONE discards the operation. No `out_valid` is produced for it.
- `in_valid` is not sampled in the cycle `rst` is high.

## Configuration
- `RCAS_SEQ_FLAGS_EN` defined: `ovf`, `zero` and `neg` are computed and registered on DONE entry as defined above.
- Not defined: the flag logic and registers are removed, and `ovf`, `zero` and `neg` are tied to 0.
- Ports exist in both builds. `result`, `c_out` and all timing are identical in both builds.

## Test plan
All scenarios use WIDTH=32 with `RCAS_SEQ_FLAGS_EN` defined.

1. Add 0x00000001 + 0xFFFFFFFF, sel=0 → `result`=0x00000000, `c_out`=1, `zero`=1, `ovf`=0, `neg`=0. `out_valid` rises exactly 8 cycles after acceptance.
2. Subtract 5 − 7, sel=1 → `result`=0xFFFFFFFE, `c_out`=0, `neg`=1, `ovf`=0, `zero`=0.
3. Add 0x7FFFFFFF + 0x00000001 → `result`=0x80000000, `ovf`=1, `neg`=1, `c_out`=0. Then subtract 0x80000000 − 1 → `result`=0x7FFFFFFF, `ovf`=1, `c_out`=1.
4. Hold `out_ready`=0 for 5 cycles in DONE while pulsing `in_valid` with new operands → `out_valid` and `result` stay stable, `in_ready`=0, and the new request is not accepted. Release `out_ready` → IDLE next edge, `in_ready`=1.
5. Assert `rst` for 1 cycle at RUN digit 4 → `out_valid` never rises for that op, and all outputs read reset values. A following op 0x12345678 + 0x11111111 gives 0x23456789 after 8 cycles.
6. Back-to-back operations with `in_valid` and `out_ready` held high → acceptances are spaced exactly 10 cycles apart. Compare 1000 random add/sub results against a reference model. Repeat with the macro undefined → flags are always 0 and `result`/`c_out` are unchanged.
